// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code helpers and defaults for the counter and its consumers
//   GRAY_WIDTH_DEF : default counter width
//   GRAY_WIDTH_MAX : widest supported counter; helpers operate at this width
//   bin2gray()     : binary to Gray, zero-extend narrower values before calling
//   gray2bin()     : Gray to binary, for downstream decoders and scoreboards
package gray_pkg;
  localparam int GRAY_WIDTH_DEF = 4;
  localparam int GRAY_WIDTH_MAX = 16;
  function automatic logic [GRAY_WIDTH_MAX-1:0] bin2gray(input logic [GRAY_WIDTH_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction
  // Zero-extended inputs decode correctly because the leading zeros leave the prefix XOR untouched.
  function automatic logic [GRAY_WIDTH_MAX-1:0] gray2bin(input logic [GRAY_WIDTH_MAX-1:0] g);
    logic [GRAY_WIDTH_MAX-1:0] b;
    b[GRAY_WIDTH_MAX-1] = g[GRAY_WIDTH_MAX-1];
    for (int i = GRAY_WIDTH_MAX - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray_counter_encode.sv
// gray_encode: combinational WIDTH-wide binary to Gray conversion
//   bin_i  : binary value
//   gray_o : Gray code of bin_i
module gray_encode
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);
  assign gray_o = WIDTH'(bin2gray(GRAY_WIDTH_MAX'(bin_i)));
endmodule

// File: rtl/gray_counter.sv
// gray_counter: binary counter with a registered Gray copy and a roll-over pulse
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance one step per cycle
//   up         : direction (1 = up), honoured only with GRAY_COUNTER_DOWN_EN defined
//   load       : synchronous load of load_bin, takes priority over en
//   load_bin   : value loaded when load is high
//   bin, gray  : registered binary count and its Gray code, always in step
//   wrap       : one-cycle pulse after a counting roll-over (never after a load)
// Define GRAY_COUNTER_DOWN_EN to enable down-counting.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);
  logic [WIDTH-1:0] bin_q, bin_d, gray_q, gray_d, step_d;
  logic             wrap_q, wrap_d, roll;
`ifdef GRAY_COUNTER_DOWN_EN
  always_comb begin
    step_d = up ? bin_q + 1'b1 : bin_q - 1'b1;
    roll   = en & (up ? &bin_q : ~|bin_q);
  end
`else
  logic unused_up;
  assign unused_up = up;
  always_comb begin
    step_d = bin_q + 1'b1;
    roll   = en & (&bin_q);
  end
`endif
  always_comb begin
    bin_d  = load ? load_bin : en ? step_d : bin_q;
    wrap_d = ~load & roll;
  end
  // Gray is derived from the next binary value so both registers update on the same edge.
  gray_encode #(.WIDTH(WIDTH)) u_enc (.bin_i(bin_d), .gray_o(gray_d));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  assign bin  = bin_q;
  assign gray = gray_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed self-checking bench for gray_counter at WIDTH=4
module tb_gray_counter;
  import gray_pkg::*;
  logic       clk = 1'b0, rst_n = 1'b1, en = 1'b0, up = 1'b1, load = 1'b0;
  logic [3:0] load_bin = '0, bin, gray, prev;
  logic       wrap;
  int         n_chk = 0, n_fail = 0;
  logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hc, 4'hd, 4'hf, 4'he, 4'ha, 4'hb, 4'h9, 4'h8};
  gray_counter #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_bin(load_bin),
    .bin(bin), .gray(gray), .wrap(wrap)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_out(input string tag, input logic [3:0] b, input logic [3:0] g, input logic w);
    check({tag, ".bin"}, 16'(bin), 16'(b));
    check({tag, ".gray"}, 16'(gray), 16'(g));
    check({tag, ".wrap"}, 16'(wrap), 16'(w));
  endtask
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_out(tag, 4'h0, 4'h0, 1'b0);
    tick();
    rst_n = 1'b1;
  endtask
  initial begin
    #2 rst_n = 1'b0;
    #1 check_out("rst_async", 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      en = ~en;
      tick();
      check_out("rst_hold", 4'h0, 4'h0, 1'b0);
    end
    rst_n = 1'b1;
    en    = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      prev = gray;
      tick();
      check("sweep.bin", 16'(bin), 16'(k % 16));
      check("sweep.gray", 16'(gray), 16'(gtab[k%16]));
      check("sweep.g2b", gray2bin(16'(gray)), 16'(k % 16));
      check("sweep.wrap", 16'(wrap), 16'(k == 16));
      check("sweep.flip", 16'($countones(prev ^ gray)), 16'd1);
    end
    repeat (5) tick();
    check_out("mid_count", 4'h6, 4'h5, 1'b0);
    async_reset("rst_mid");
    repeat (3) tick();
    check_out("pre_load", 4'h3, 4'h2, 1'b0);
    load     = 1'b1;
    load_bin = 4'hf;
    tick();
    check_out("load_prio", 4'hf, 4'h8, 1'b0);
    load = 1'b0;
    tick();
    check_out("load_roll", 4'h0, 4'h0, 1'b1);
    async_reset("rst_drop_wrap");
    load     = 1'b1;
    load_bin = 4'ha;
    tick();
    load = 1'b0;
    en   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("hold", 4'ha, 4'hf, 1'b0);
    end
    load     = 1'b1;
    load_bin = 4'hf;
    tick();
    load_bin = 4'h0;
    en       = 1'b1;
    tick();
    check_out("load_zero", 4'h0, 4'h0, 1'b0);
    load_bin = 4'h1;
    tick();
    check_out("load_one", 4'h1, 4'h1, 1'b0);
    load = 1'b0;
    up   = 1'b0;
`ifdef GRAY_COUNTER_DOWN_EN
    tick();
    check_out("down0", 4'h0, 4'h0, 1'b0);
    tick();
    check_out("down_wrap", 4'hf, 4'h8, 1'b1);
    up = 1'b1;
    tick();
    check_out("dir_flip", 4'h0, 4'h0, 1'b1);
`else
    tick();
    check_out("nodown0", 4'h2, 4'h3, 1'b0);
    tick();
    check_out("nodown1", 4'h3, 4'h2, 1'b0);
    up = 1'b1;
    tick();
    check_out("noflip", 4'h4, 4'h6, 1'b0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Synchronous counter that generates the binary sequence and its registered Gray-code equivalent in the same cycle.
- Acts as the upstream source for the binary→Gray conversion path, producing glitch-free Gray values for FIFO pointers and cross-domain sampling.
- Supports enable, synchronous load and a wrap pulse; down-counting is optional.

Parameters:
- WIDTH, 4, counter width in bits (legal range 2..16).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement. Only honoured when GRAY_COUNTER_DOWN_EN is defined.
- load  input  1  synchronous load strobe.
- load_bin  input  WIDTH  binary value taken when load=1.
- bin  output  WIDTH  registered binary count.
- gray  output  WIDTH  registered Gray code of bin: gray = bin ^ (bin >> 1).
- wrap  output  1  one-cycle pulse, registered, on a counting roll-over.

Behaviour:
- Reset (rst_n=0, asynchronous): bin=0, gray=0, wrap=0 immediately, independent of clk. Release is synchronous to the next clk edge; the first count occurs on the first edge with rst_n=1 and en=1.
- Next-state priority per edge: load > en > hold.
- load=1: bin←load_bin, gray←bin2gray(load_bin), wrap←0. en is ignored that cycle.
- en=1, load=0, increment: bin←bin+1 modulo 2^WIDTH.
- en=1, load=0, decrement (macro only): bin←bin−1 modulo 2^WIDTH.
- en=0, load=0: bin and gray hold; wrap←0.
- gray is computed from the next binary value and registered alongside bin. bin and gray always correspond in the same cycle; there is zero added latency between them.
- gray is a pure flop output, not combinational, so it is safe to sample asynchronously.
- Consecutive counting steps change exactly one gray bit. A load may change several bits.
- wrap←1 for one cycle after an increment step from 2^WIDTH−1 to 0, or a decrement step from 0 to 2^WIDTH−1. Otherwise wrap←0. A load never asserts wrap, even when load_bin=0.
- Held en=1 at max value: wraps and keeps counting; wrap pulses once per roll-over.
- Reset asserted mid-count: all outputs go to 0 asynchronously and a pending wrap is dropped.
- No arithmetic overflow flag; width is fixed at WIDTH, carry is discarded.

Optional Feature:
- Macro: GRAY_COUNTER_DOWN_EN.
- Defined: up selects direction each cycle. Direction changes take effect on the same edge, with no dead cycle. Down-wrap 0→max pulses wrap.
- Undefined: up port is still present but ignored; the counter only increments. Decrement logic is not synthesised.

Decomposition:
- Shared package gray_pkg contains:
  - function bin2gray(bin) → bin ^ (bin >> 1), WIDTH-generic;
  - function gray2bin, for the downstream decoder and bench scoreboard;
  - constant GRAY_WIDTH_DEF = 4.
- One sub-module is natural: gray_encode, a combinational WIDTH-parameterised wrapper of bin2gray feeding the gray register's D input. Counter register and wrap logic stay in gray_counter.

Test Plan:
- Reset/async: hold rst_n=0, toggle en; assert rst_n=0 mid-count at bin=4'b0110 between edges → bin=0, gray=0, wrap=0 immediately, without waiting for clk.
- Full up sweep (WIDTH=4): rst_n=1, en=1 for 17 cycles.
  - gray follows 0000,0001,0011,0010,0110,…,1000, then back to 0000.
  - Exactly one gray bit flips per step.
  - wrap=1 only in the cycle bin returns to 0000.
- Load priority: bin=4'b0011, load=1, load_bin=4'b1111, en=1 → bin=1111, gray=1000, wrap=0. Next cycle with en=1 → bin=0000, gray=0000, wrap=1.
- Hold: en=0, load=0 for 5 cycles at bin=4'b1010 → bin=1010, gray=1111 stable, wrap=0.
- Load zero: load=1, load_bin=0 while bin=4'b1111 → bin=0, wrap stays 0.
- Down count (GRAY_COUNTER_DOWN_EN defined): from bin=0001, en=1, up=0.
  - Sequence 0000, 1111 with gray 0000, 1000; wrap=1 on the 0000→1111 step.
  - Flip up=1 → next bin=0000.
  - Without the macro, the same stimulus increments to 0010.
